instr_loader: RTL and testbench

//  Upstream feeder for the 9-bit accumulator CPU core.
//  - Assembles 9-bit instruction words from a 1-bit serial pin stream, framed by a valid strobe.
//  - Buffers the words in a small FIFO.
//  - Issues one word per cycle to the core as INSTRUCTION plus a single-cycle write_en, gated by RUN.
//  - Exists because the TinyTapeout pin budget cannot carry 9 parallel instruction bits.

---
 rtl/cpu_defs.sv | 12 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/instr_loader.sv | 131 +++++++++++++
 tb/tb_instr_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the accumulator CPU and its instruction feeder.
// Holds the instruction width and the serial receiver state encoding.
package cpu_defs;

    localparam int INSTR_W = 9;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, depth+1 pointer scheme, combinational read port.
// Latency: a word pushed at edge N is visible on dout and counted from N+1.
// Backpressure: a push while full is ignored unless a pop frees a slot on the same edge.
module sync_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [CW-1:0]    wptr;
    logic [CW-1:0]    rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign count = wptr - rptr;
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/instr_loader.sv
// Serial-to-parallel instruction feeder for the 9-bit accumulator core.
// Latency: last serial bit at edge N -> write_en high after edge N+1 when RUN and FIFO was empty.
// Backpressure: RUN low freezes issue; a frame completing into a full FIFO with no pop is dropped, OVERFLOW sticks.
module instr_loader
    import cpu_defs::*;
#(
    parameter int WIDTH = INSTR_W,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SDI,
    input  logic             SVALID,
    input  logic             RUN,
    output logic [WIDTH-1:0] INSTRUCTION,
    output logic             write_en,
    output logic [CW-1:0]    COUNT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             OVERFLOW,
    output logic             ABORT
);

    localparam int BW = $clog2(WIDTH);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [BW-1:0]    bitcnt;
    logic [BW-1:0]    bitcnt_nxt;
    logic             frame_done;
    logic             abort_nxt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] fifo_dout;
    logic             pop;

    // The completing bit is merged combinationally so the word is pushed on that same edge.
    assign word = {shreg[WIDTH-2:0], SDI};

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        frame_done = 1'b0;
        abort_nxt  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (SVALID) begin
                    shreg_nxt  = {{(WIDTH-1){1'b0}}, SDI};
                    bitcnt_nxt = BW'(1);
                    state_nxt  = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (SVALID) begin
                    shreg_nxt = word;
                    if (bitcnt == BW'(WIDTH-1)) begin
                        frame_done = 1'b1;
                        bitcnt_nxt = '0;
                        state_nxt  = RX_IDLE;
                    end else begin
                        bitcnt_nxt = bitcnt + 1'b1;
                    end
                end else begin
                    abort_nxt  = 1'b1;
                    shreg_nxt  = '0;
                    bitcnt_nxt = '0;
                    state_nxt  = RX_IDLE;
                end
            end
            default: begin
                state_nxt  = RX_IDLE;
                shreg_nxt  = '0;
                bitcnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= RX_IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            ABORT  <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            bitcnt <= bitcnt_nxt;
            ABORT  <= abort_nxt;
        end
    end

    assign pop = RUN && !EMPTY;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (frame_done),
        .pop   (pop),
        .din   (word),
        .dout  (fifo_dout),
        .count (COUNT),
        .full  (FULL),
        .empty (EMPTY)
    );

    // A full FIFO is never empty, so a same-edge pop is simply RUN.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OVERFLOW <= 1'b0;
        end else if (frame_done && FULL && !RUN) begin
            OVERFLOW <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            INSTRUCTION <= '0;
            write_en    <= 1'b0;
        end else begin
            write_en <= pop;
            if (pop) INSTRUCTION <= fifo_dout;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed tables, corner sequences, randomized model comparison.
module tb_instr_loader;
    import cpu_defs::*;

    localparam int W = 9;
    localparam int D = 4;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         SDI;
    logic         SVALID;
    logic         RUN;
    logic [W-1:0] INSTRUCTION;
    logic         write_en;
    logic [2:0]   COUNT;
    logic         FULL;
    logic         EMPTY;
    logic         OVERFLOW;
    logic         ABORT;

    instr_loader #(.WIDTH(W), .DEPTH(D), .CW(3)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SDI         (SDI),
        .SVALID      (SVALID),
        .RUN         (RUN),
        .INSTRUCTION (INSTRUCTION),
        .write_en    (write_en),
        .COUNT       (COUNT),
        .FULL        (FULL),
        .EMPTY       (EMPTY),
        .OVERFLOW    (OVERFLOW),
        .ABORT       (ABORT)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] issued[$];
    int           abort_cnt = 0;

    always @(negedge CLK) begin
        if (!RESET) begin
            if (write_en) issued.push_back(INSTRUCTION);
            if (ABORT) abort_cnt++;
        end
    end

    typedef struct {
        int           nbits;
        logic [W-1:0] word;
        int           exp_aborts;
        int           exp_issues;
        logic [W-1:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        SDI    = b;
        SVALID = 1'b1;
        tick();
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[W-1-i]);
    endtask

    task automatic apply_reset();
        RESET  = 1'b1;
        SVALID = 1'b0;
        SDI    = 1'b0;
        RUN    = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        issued.delete();
        abort_cnt = 0;
    endtask

    logic [W-1:0] seq4[4];
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_acc;
    logic [W-1:0] m_instr;
    logic         m_we;
    logic         m_ovf;
    logic         m_abort;
    int           m_n;
    int           edges;

    initial begin
        vecs[0] = '{9, 9'h153, 0, 1, 9'h153};
        vecs[1] = '{5, 9'h1FF, 1, 0, 9'h000};
        vecs[2] = '{9, 9'h07E, 0, 1, 9'h07E};
        vecs[3] = '{9, 9'h000, 0, 1, 9'h000};
        vecs[4] = '{9, 9'h1FF, 0, 1, 9'h1FF};
        vecs[5] = '{1, 9'h100, 1, 0, 9'h000};
        vecs[6] = '{8, 9'h0AA, 1, 0, 9'h000};
        seq4[0] = 9'h001;
        seq4[1] = 9'h0FF;
        seq4[2] = 9'h1AA;
        seq4[3] = 9'h155;

        apply_reset();
        check("rst.instr", INSTRUCTION, 0);
        check("rst.we", write_en, 0);
        check("rst.count", COUNT, 0);
        check("rst.empty", EMPTY, 1);
        check("rst.full", FULL, 0);
        check("rst.ovf", OVERFLOW, 0);
        check("rst.abort", ABORT, 0);

        // Single frame, issue latency
        RUN = 1'b1;
        send_bits(9'h153, 9);
        SVALID = 1'b0;
        edges = 1;
        while (!write_en && edges < 8) begin
            tick();
            edges++;
        end
        check("t1.delay", edges, 2);
        check("t1.instr", INSTRUCTION, 9'h153);
        repeat (3) tick();
        check("t1.nissue", issued.size(), 1);

        // Fill with RUN low, then drain in order
        apply_reset();
        for (int i = 0; i < 4; i++) send_bits(seq4[i], 9);
        SVALID = 1'b0;
        check("t2.full", FULL, 1);
        check("t2.count", COUNT, 4);
        RUN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t2.we%0d", i), write_en, 1);
            check($sformatf("t2.instr%0d", i), INSTRUCTION, seq4[i]);
        end
        check("t2.empty", EMPTY, 1);
        tick();
        check("t2.we_off", write_en, 0);

        // Overflow drops the fifth frame
        RUN = 1'b0;
        for (int i = 0; i < 4; i++) send_bits(seq4[i], 9);
        send_bits(9'h0F0, 9);
        SVALID = 1'b0;
        check("t3.ovf", OVERFLOW, 1);
        check("t3.count", COUNT, 4);
        RUN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3.instr%0d", i), INSTRUCTION, seq4[i]);
        end
        tick();
        check("t3.we_off", write_en, 0);
        check("t3.hold", INSTRUCTION, 9'h155);
        check("t3.empty", EMPTY, 1);

        // Push into a full FIFO on the same edge as a pop
        apply_reset();
        for (int i = 0; i < 4; i++) send_bits(seq4[i], 9);
        send_bits(9'h0A5, 8);
        RUN = 1'b1;
        send_bit(1'b1);
        SVALID = 1'b0;
        check("t4.we", write_en, 1);
        check("t4.instr", INSTRUCTION, seq4[0]);
        check("t4.count", COUNT, 4);
        check("t4.ovf", OVERFLOW, 0);
        for (int i = 1; i < 5; i++) begin
            tick();
            check($sformatf("t4.instr%0d", i), INSTRUCTION, (i < 4) ? seq4[i] : 9'h0A5);
        end
        tick();
        check("t4.empty", EMPTY, 1);

        // Abort after 5 bits, then a good frame
        apply_reset();
        RUN = 1'b1;
        send_bits(9'h1FF, 5);
        SVALID = 1'b0;
        tick();
        check("t5.abort", ABORT, 1);
        check("t5.count", COUNT, 0);
        tick();
        check("t5.abort_off", ABORT, 0);
        send_bits(9'h07E, 9);
        SVALID = 1'b0;
        repeat (3) tick();
        check("t5.nissue", issued.size(), 1);
        if (issued.size() > 0) check("t5.word", issued[0], 9'h07E);
        check("t5.naborts", abort_cnt, 1);

        // Table of single transactions with RUN held high
        apply_reset();
        RUN = 1'b1;
        foreach (vecs[k]) begin
            issued.delete();
            abort_cnt = 0;
            send_bits(vecs[k].word, vecs[k].nbits);
            SVALID = 1'b0;
            repeat (4) tick();
            check($sformatf("vec%0d.aborts", k), abort_cnt, vecs[k].exp_aborts);
            check($sformatf("vec%0d.issues", k), issued.size(), vecs[k].exp_issues);
            if (vecs[k].exp_issues > 0 && issued.size() > 0)
                check($sformatf("vec%0d.word", k), issued[$], vecs[k].exp_last);
            check($sformatf("vec%0d.count", k), COUNT, 0);
        end

        // Asynchronous reset mid-frame with two words queued
        apply_reset();
        send_bits(9'h011, 9);
        send_bits(9'h022, 9);
        send_bits(9'h1C3, 4);
        check("t6.pre_count", COUNT, 2);
        #2;
        RESET  = 1'b1;
        SVALID = 1'b0;
        #1;
        check("t6.instr", INSTRUCTION, 0);
        check("t6.we", write_en, 0);
        check("t6.count", COUNT, 0);
        check("t6.empty", EMPTY, 1);
        check("t6.full", FULL, 0);
        check("t6.ovf", OVERFLOW, 0);
        check("t6.abort", ABORT, 0);
        tick();
        RESET = 1'b0;
        issued.delete();
        abort_cnt = 0;
        RUN = 1'b1;
        send_bits(9'h100, 9);
        SVALID = 1'b0;
        repeat (5) tick();
        check("t6.nissue", issued.size(), 1);
        if (issued.size() > 0) check("t6.word", issued[0], 9'h100);
        check("t6.naborts", abort_cnt, 0);

        // Randomized traffic against a queue model
        apply_reset();
        m_q.delete();
        m_acc   = '0;
        m_instr = '0;
        m_we    = 1'b0;
        m_ovf   = 1'b0;
        m_n     = 0;
        for (int c = 0; c < 2000; c++) begin
            automatic int  run_pct = (c / 200) % 3 == 0 ? 10 : ((c / 200) % 3 == 1 ? 50 : 90);
            automatic logic sv = ($urandom_range(0, 99) < 88);
            automatic logic sd = 1'($urandom_range(0, 1));
            automatic logic rn = ($urandom_range(0, 99) < run_pct);
            automatic logic done = 1'b0;
            SVALID = sv;
            SDI    = sd;
            RUN    = rn;
            m_abort = 1'b0;
            if (sv) begin
                m_acc = {m_acc[W-2:0], sd};
                m_n++;
                if (m_n == W) begin
                    done = 1'b1;
                    m_n  = 0;
                end
            end else if (m_n > 0) begin
                m_abort = 1'b1;
                m_n     = 0;
            end
            if (rn && m_q.size() > 0) begin
                m_instr = m_q.pop_front();
                m_we    = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (done) begin
                if (m_q.size() < D) m_q.push_back(m_acc);
                else m_ovf = 1'b1;
            end
            tick();
            check($sformatf("rnd%0d.we", c), write_en, m_we);
            check($sformatf("rnd%0d.instr", c), INSTRUCTION, m_instr);
            check($sformatf("rnd%0d.count", c), COUNT, m_q.size());
            check($sformatf("rnd%0d.full", c), FULL, m_q.size() == D);
            check($sformatf("rnd%0d.empty", c), EMPTY, m_q.size() == 0);
            check($sformatf("rnd%0d.ovf", c), OVERFLOW, m_ovf);
            check($sformatf("rnd%0d.abort", c), ABORT, m_abort);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
